// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the datapath: opcodes, immediate and write-back selects,
// branch funct3 codes and the ALU operation set used by the optional full ALU.
package riscv_pkg;

    localparam logic [6:0] OP_ADD    = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RFIN_ALU   = 2'b00;
    localparam logic [1:0] RFIN_MEM   = 2'b01;
    localparam logic [1:0] RFIN_PC4   = 2'b10;
    localparam logic [1:0] RFIN_AUIPC = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // SUB only exists as an R-type encoding; ADDI with IR[30] set is still an add.
    function automatic alu_op_e alu_decode(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic       bit30);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (opcode == OP_ADD && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_datapath_if.sv
// Control-unit and memory bundle of the RV32I datapath. The master side is the control FSM
// plus the memories; the slave side is the datapath.
interface riscv_datapath_if;
    logic        load_IR, load_PC, we_RF, we_DM;
    logic        sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B, sel_PC_RF;
    logic [2:0]  sel_imme;
    logic [1:0]  sel_RF_in;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        br_taken;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_we;
    logic [31:0] instret;

    modport master (
        output load_IR, load_PC, we_RF, we_DM, sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B,
               sel_PC_RF, sel_imme, sel_RF_in, imem_rdata, dmem_rdata,
        input  opcode, funct3, br_taken, imem_addr, dmem_addr, dmem_wdata, dmem_we, instret
    );

    modport slave (
        input  load_IR, load_PC, we_RF, we_DM, sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B,
               sel_PC_RF, sel_imme, sel_RF_in, imem_rdata, dmem_rdata,
        output opcode, funct3, br_taken, imem_addr, dmem_addr, dmem_wdata, dmem_we, instret
    );
endinterface

// File: rtl/riscv_regfile.sv
// 32x32 RV32I register file: two asynchronous read ports, one synchronous write port,
// x0 hardwired to zero, synchronous active-high reset of every entry.
module riscv_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data
);
    logic [31:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset so every register reads 0 afterwards; that forces flops, not a RAM macro.
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && i_rd_addr != 5'd0) begin
            // NOTE: non-blocking so a same-cycle read still sees the old value.
            r_regs[i_rd_addr] <= i_wdata;
        end
    end

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];
endmodule

// File: rtl/riscv_datapath.sv
// Multicycle RV32I datapath: PC, IR, register file, immediate/ALU/branch/next-PC logic.
// Define DATAPATH_FULL_ALU_EN for the full RV32I ALU on OP/OP-IMM; otherwise the ALU only adds.
module riscv_datapath
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input logic             clk,
    input logic             rst,
    riscv_datapath_if.slave io_bus
);
    logic [XLEN-1:0] r_pc, r_ir, r_instret;
    logic [XLEN-1:0] w_rs1, w_rs2, w_imm, w_alu_a, w_alu_b, w_alu;
    logic [XLEN-1:0] w_pc_seq, w_pc_base, w_pc_tgt, w_next_pc, w_rf_wdata;
    logic            w_br_taken;

    riscv_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_rs1_addr (r_ir[19:15]),
        .i_rs2_addr (r_ir[24:20]),
        .i_rd_addr  (r_ir[11:7]),
        .i_we       (io_bus.we_RF),
        .i_wdata    (w_rf_wdata),
        .o_rs1_data (w_rs1),
        .o_rs2_data (w_rs2)
    );

    always_comb begin
        // NOTE: default first so no path through the case leaves w_imm unassigned (no latch).
        w_imm = '0;
        case (io_bus.sel_imme)
            IMM_I:   w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
            IMM_S:   w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            IMM_B:   w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            IMM_J:   w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            IMM_U:   w_imm = {r_ir[31:12], 12'b0};
            default: w_imm = '0;
        endcase
    end

    assign w_alu_a = io_bus.sel_ALU_A ? w_rs1 : r_pc;
    assign w_alu_b = io_bus.sel_ALU_B ? w_rs2 : w_imm;

`ifdef DATAPATH_FULL_ALU_EN
    alu_op_e w_alu_op;

    always_comb begin
        w_alu_op = ALU_ADD;
        if (r_ir[6:0] == OP_ADD || r_ir[6:0] == OP_ADDI)
            w_alu_op = alu_decode(r_ir[6:0], r_ir[14:12], r_ir[30]);
    end

    always_comb begin
        w_alu = w_alu_a + w_alu_b;
        case (w_alu_op)
            ALU_SUB:  w_alu = w_alu_a - w_alu_b;
            ALU_SLL:  w_alu = w_alu_a << w_alu_b[4:0];
            ALU_SLT:  w_alu = {31'b0, $signed(w_alu_a) < $signed(w_alu_b)};
            ALU_SLTU: w_alu = {31'b0, w_alu_a < w_alu_b};
            ALU_XOR:  w_alu = w_alu_a ^ w_alu_b;
            ALU_SRL:  w_alu = w_alu_a >> w_alu_b[4:0];
            ALU_SRA:  w_alu = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
            ALU_OR:   w_alu = w_alu_a | w_alu_b;
            ALU_AND:  w_alu = w_alu_a & w_alu_b;
            default:  w_alu = w_alu_a + w_alu_b;
        endcase
    end
`else
    assign w_alu = w_alu_a + w_alu_b;
`endif

    always_comb begin
        w_br_taken = 1'b0;
        case (r_ir[14:12])
            F3_BEQ:  w_br_taken = (w_rs1 == w_rs2);
            F3_BNE:  w_br_taken = (w_rs1 != w_rs2);
            F3_BLT:  w_br_taken = ($signed(w_rs1) <  $signed(w_rs2));
            F3_BGE:  w_br_taken = ($signed(w_rs1) >= $signed(w_rs2));
            F3_BLTU: w_br_taken = (w_rs1 <  w_rs2);
            F3_BGEU: w_br_taken = (w_rs1 >= w_rs2);
            default: w_br_taken = 1'b0;
        endcase
    end

    // JALR-style targets (base = rs1) drop bit 0; PC-relative targets are already even.
    assign w_pc_seq  = r_pc + 32'd4;
    assign w_pc_base = io_bus.sel_PC_A ? r_pc : w_rs1;
    always_comb begin
        w_pc_tgt = w_pc_base + w_imm;
        if (!io_bus.sel_PC_A) w_pc_tgt[0] = 1'b0;
    end
    assign w_next_pc = (io_bus.sel_PC_RF || (io_bus.sel_PC_B && w_br_taken)) ? w_pc_tgt : w_pc_seq;

    always_comb begin
        w_rf_wdata = w_alu;
        case (io_bus.sel_RF_in)
            RFIN_ALU:   w_rf_wdata = w_alu;
            RFIN_MEM:   w_rf_wdata = io_bus.dmem_rdata;
            RFIN_PC4:   w_rf_wdata = w_pc_seq;
            RFIN_AUIPC: w_rf_wdata = r_pc + w_imm;
            default:    w_rf_wdata = w_alu;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= NOP_INSTR;
            r_instret <= '0;
        end else begin
            if (io_bus.load_IR) r_ir <= io_bus.imem_rdata;
            if (io_bus.load_PC) begin
                r_pc      <= w_next_pc;
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign io_bus.opcode     = r_ir[6:0];
    assign io_bus.funct3     = r_ir[14:12];
    assign io_bus.br_taken   = w_br_taken;
    assign io_bus.imem_addr  = r_pc;
    assign io_bus.dmem_addr  = w_alu;
    assign io_bus.dmem_wdata = w_rs2;
    assign io_bus.dmem_we    = io_bus.we_DM;
    assign io_bus.instret    = r_instret;
endmodule
